// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set generator: turns GMII TXD/TX_EN/TX_ER into /I/, /S/, data, /T/, /R/ octets for the 8B/10B encoder.
// Optional build macro PCS_TX_ERR_PROP_EN: replaces TX_ER-flagged data octets with /V/ (K30.7).
module pcs_tx_ordered_set (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic [7:0] TXD,
  input  logic       TX_EN,
  input  logic       TX_ER,
  output logic [7:0] tx_o_set,
  output logic       tx_is_k,
  output logic       tx_even,
  output logic       transmitting
);

  localparam logic [2:0] IDLE_K = 3'd0;
  localparam logic [2:0] IDLE_D = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] END_T  = 3'd4;
  localparam logic [2:0] END_R1 = 3'd5;
  localparam logic [2:0] END_R2 = 3'd6;

  localparam logic [7:0] OS_K28_5 = 8'hBC;
  localparam logic [7:0] OS_D16_2 = 8'h50;
  localparam logic [7:0] OS_S     = 8'hFB;
  localparam logic [7:0] OS_T     = 8'hFD;
  localparam logic [7:0] OS_R     = 8'hF7;
  localparam logic [7:0] OS_V     = 8'hFE;

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [7:0] o_set_r;
  logic [7:0] o_set_nxt_s;
  logic       is_k_r;
  logic       is_k_nxt_s;
  logic       even_r;
  logic       xmit_r;
  logic       xmit_nxt_s;
  logic [7:0] data_s;
  logic       data_k_s;

  // Data slot contents: raw octet, or /V/ when error propagation is built in
`ifdef PCS_TX_ERR_PROP_EN
  always_comb begin
    if (TX_ER) begin
      data_s   = OS_V;
      data_k_s = 1'b1;
    end else begin
      data_s   = TXD;
      data_k_s = 1'b0;
    end
  end
`else
  always_comb begin
    data_s   = TXD;
    data_k_s = 1'b0;
  end
`endif

  // Next-state decode; /S/ only reachable from IDLE_D so it always lands even
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE_K: state_nxt_s = IDLE_D;
      IDLE_D: begin
        if (TX_EN) state_nxt_s = START;
        else       state_nxt_s = IDLE_K;
      end
      START: begin
        if (TX_EN) state_nxt_s = DATA;
        else       state_nxt_s = END_T;
      end
      DATA: begin
        if (TX_EN) state_nxt_s = DATA;
        else       state_nxt_s = END_T;
      end
      END_T: state_nxt_s = END_R1;
      END_R1: begin
        if (even_r) state_nxt_s = END_R2;
        else        state_nxt_s = IDLE_K;
      end
      END_R2:  state_nxt_s = IDLE_K;
      default: state_nxt_s = IDLE_K;
    endcase
  end

  // Output octet for the state being entered, so outputs flop alongside state
  always_comb begin
    o_set_nxt_s = OS_K28_5;
    is_k_nxt_s  = 1'b1;
    xmit_nxt_s  = 1'b0;
    case (state_nxt_s)
      IDLE_K: begin
        o_set_nxt_s = OS_K28_5;
        is_k_nxt_s  = 1'b1;
      end
      IDLE_D: begin
        o_set_nxt_s = OS_D16_2;
        is_k_nxt_s  = 1'b0;
      end
      START: begin
        o_set_nxt_s = OS_S;
        is_k_nxt_s  = 1'b1;
        xmit_nxt_s  = 1'b1;
      end
      DATA: begin
        o_set_nxt_s = data_s;
        is_k_nxt_s  = data_k_s;
        xmit_nxt_s  = 1'b1;
      end
      END_T: begin
        o_set_nxt_s = OS_T;
        is_k_nxt_s  = 1'b1;
        xmit_nxt_s  = 1'b1;
      end
      END_R1, END_R2: begin
        o_set_nxt_s = OS_R;
        is_k_nxt_s  = 1'b1;
        xmit_nxt_s  = 1'b1;
      end
      default: begin
        o_set_nxt_s = OS_K28_5;
        is_k_nxt_s  = 1'b1;
        xmit_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces IDLE_K on an even position
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_r <= IDLE_K;
      o_set_r <= OS_K28_5;
      is_k_r  <= 1'b1;
      even_r  <= 1'b1;
      xmit_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      o_set_r <= o_set_nxt_s;
      is_k_r  <= is_k_nxt_s;
      even_r  <= ~even_r;
      xmit_r  <= xmit_nxt_s;
    end
  end

  assign tx_o_set     = o_set_r;
  assign tx_is_k      = is_k_r;
  assign tx_even      = even_r;
  assign transmitting = xmit_r;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Scoreboard bench for pcs_tx_ordered_set: directed GMII vectors push hand-computed expected octets; a monitor pops and compares each cycle.
module tb_pcs_tx_ordered_set;

  logic       GTX_CLK;
  logic       mr_main_reset;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic [7:0] tx_o_set;
  logic       tx_is_k;
  logic       tx_even;
  logic       transmitting;

  typedef struct {
    logic [7:0] o;
    logic       k;
    logic       ev;
    logic       tr;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_n = 0;

  pcs_tx_ordered_set dut (
    .GTX_CLK      (GTX_CLK),
    .mr_main_reset(mr_main_reset),
    .TXD          (TXD),
    .TX_EN        (TX_EN),
    .TX_ER        (TX_ER),
    .tx_o_set     (tx_o_set),
    .tx_is_k      (tx_is_k),
    .tx_even      (tx_even),
    .transmitting (transmitting)
  );

  initial GTX_CLK = 1'b0;
  always #5 GTX_CLK = ~GTX_CLK;

  task automatic check_now(input string name, input logic [7:0] eo, input logic ek,
                           input logic eev, input logic etr);
    total = total + 1;
    if ({tx_o_set, tx_is_k, tx_even, transmitting} !== {eo, ek, eev, etr}) begin
      bad = bad + 1;
      $display("FAIL %s got o=%h k=%b ev=%b tr=%b exp o=%h k=%b ev=%b tr=%b",
               name, tx_o_set, tx_is_k, tx_even, transmitting, eo, ek, eev, etr);
    end
  endtask

  // Drive one octet (called between edges) and queue the output expected after the next edge
  task automatic step(input logic en, input logic er, input logic [7:0] d,
                      input logic [7:0] eo, input logic ek, input logic eev, input logic etr);
    exp_t e;
    TX_EN = en;
    TX_ER = er;
    TXD   = d;
    e.o = eo; e.k = ek; e.ev = eev; e.tr = etr; e.id = step_n;
    step_n = step_n + 1;
    exp_q.push_back(e);
    @(negedge GTX_CLK);
  endtask

  // Monitor: output is presented every cycle, compare against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge GTX_CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total = total + 1;
        if ({tx_o_set, tx_is_k, tx_even, transmitting} !== {e.o, e.k, e.ev, e.tr}) begin
          bad = bad + 1;
          $display("FAIL step%0d got o=%h k=%b ev=%b tr=%b exp o=%h k=%b ev=%b tr=%b",
                   e.id, tx_o_set, tx_is_k, tx_even, transmitting, e.o, e.k, e.ev, e.tr);
        end
      end
    end
  end

  initial begin
    logic [7:0] err_o;
    logic       err_k;
`ifdef PCS_TX_ERR_PROP_EN
    err_o = 8'hFE; err_k = 1'b1;
`else
    err_o = 8'h23; err_k = 1'b0;
`endif
    mr_main_reset = 1'b0;
    TX_EN = 1'b0;
    TX_ER = 1'b0;
    TXD   = 8'h00;
    #11;
    check_now("reset_hold", 8'hBC, 1'b1, 1'b1, 1'b0);
    #1;
    mr_main_reset = 1'b1;

    // reset idle: alternating /I/ with K28.5 even
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);

    // even start, 8 octets
    step(1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h55, 8'h55, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hD5, 8'hD5, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hC5, 8'hC5, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hC5, 8'hC5, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h07, 8'h07, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hC5, 8'hC5, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);

    // odd start: TX_EN rises in IDLE_K, AA dropped, 55 replaced by /S/
    step(1'b1, 1'b0, 8'hAA, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hD5, 8'hD5, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);

    // 4-octet packet: /T/R/ then K28.5
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h02, 8'h02, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);

    // 5-octet packet: /T/R/R/ then K28.5
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h02, 8'h02, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h04, 8'h04, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);

    // TX_ER on the third data octet
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h21, 8'h21, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h22, 8'h22, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'h23, err_o, err_k, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h24, 8'h24, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);

    // mid-packet reset
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h31, 8'h31, 1'b0, 1'b0, 1'b1);
    mr_main_reset = 1'b0;
    #1;
    check_now("midpkt_rst_async", 8'hBC, 1'b1, 1'b1, 1'b0);
    @(posedge GTX_CLK);
    #1;
    check_now("midpkt_rst_hold", 8'hBC, 1'b1, 1'b1, 1'b0);
    @(negedge GTX_CLK);
    mr_main_reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);

    @(negedge GTX_CLK);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain got=%0d left exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
